// File: rtl/serial_subtract.sv
// Bit-serial unsigned subtractor: one full-subtract step per clock, LSB first,
// with the borrow registered and fed back. Start/busy/done handshake.
module serial_subtract #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_brw;
  logic             r_borrow;
  logic             r_busy;
  logic             r_done;
  logic             w_load;
  logic             w_last;
  logic             w_d;
  logic             w_brw_n;
  logic [WIDTH-1:0] w_res_n;

  function automatic logic fs_diff(input logic x, input logic y, input logic bi);
    return x ^ y ^ bi;
  endfunction

  function automatic logic fs_borrow(input logic x, input logic y, input logic bi);
    return (~x & y) | (~(x ^ y) & bi);
  endfunction

  always_comb begin
    w_d     = fs_diff(r_sa[0], r_sb[0], r_brw);
    w_brw_n = fs_borrow(r_sa[0], r_sb[0], r_brw);
    w_res_n = {w_d, r_res[WIDTH-1:1]};
    w_last  = (r_state == SHIFT) && (r_cnt == CW'(WIDTH - 1));
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = SHIFT;
          w_load = 1'b1;
        end
      end
      SHIFT: begin
        if (w_last) w_next = DONE;
      end
      DONE: begin
        // A start in the completion cycle chains straight into the next operation.
        if (start) begin
          w_next = SHIFT;
          w_load = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sa     <= '0;
      r_sb     <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_brw    <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == SHIFT);
      r_done  <= (w_next == DONE);
      if (w_load) begin
        r_sa  <= a;
        r_sb  <= b;
        r_res <= '0;
        r_cnt <= '0;
        r_brw <= 1'b0;
      end else if (r_state == SHIFT) begin
        r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
        r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
        r_res <= w_res_n;
        r_cnt <= r_cnt + CW'(1);
        r_brw <= w_brw_n;
        if (w_last) begin
          r_diff   <= w_res_n;
          r_borrow <= w_brw_n;
        end
      end
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign diff      = r_diff;
  assign borrowOut = r_borrow;

endmodule

// File: tb/tb_serial_subtract.sv
// Bench for serial_subtract (WIDTH=8): vector table plus hand-written corner
// sequences; expected results queued at issue and checked when done pulses.
module tb_serial_subtract;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrowOut;

  serial_subtract #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrowOut(borrowOut)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         br;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] d;
    logic         br;
  } vec_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      chk("done_single_cycle", {31'd0, prev_done}, 32'd0);
      if (q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("diff", {24'd0, diff}, {24'd0, e.d});
        chk("borrowOut", {31'd0, borrowOut}, {31'd0, e.br});
      end
    end
    prev_done = done;
  end

  // Drives a one-cycle start; returns at the negedge after the accepting edge.
  task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic push,
                       input logic [W-1:0] ed, input logic eb);
    exp_t e;
    start = 1'b1;
    a = ia;
    b = ib;
    if (push) begin
      e.d  = ed;
      e.br = eb;
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
  endtask

  // Counts busy cycles until done; returns at the negedge where done is high.
  task automatic wait_done(input int exp_busy);
    int n;
    bit seen;
    n = 0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) n++;
      @(negedge clk);
    end
    chk("done_seen", {31'd0, seen}, 32'd1);
    chk("busy_cycles", n, exp_busy);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1};
    vecs[2] = '{8'hA5, 8'hA5, 8'h00, 1'b0};
    vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0};
    for (int i = 5; i < 8; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      vecs[i] = '{ra, rb, W'(ra - rb), (ra < rb)};
    end

    // Reset, including a start asserted alongside it, which must be ignored.
    start = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_diff_borrow", {23'd0, borrowOut, diff}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", {30'd0, busy, done}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      issue(vecs[i].a, vecs[i].b, 1'b1, vecs[i].d, vecs[i].br);
      wait_done(W);
      @(negedge clk);
      chk("done_falls", {31'd0, done}, 32'd0);
      @(negedge clk);
    end

    // Start during SHIFT is ignored.
    issue(8'h10, 8'h01, 1'b1, 8'h0F, 1'b0);
    repeat (2) @(negedge clk);
    start = 1'b1;
    a = 8'h00;
    b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_done(W - 3);
    repeat (12) @(negedge clk);
    chk("ignored_start_queue_empty", q.size(), 0);

    // Reset mid-operation abandons it without a done pulse.
    issue(8'h80, 8'h7F, 1'b0, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("midrst_diff_borrow", {23'd0, borrowOut, diff}, 32'd0);
    repeat (12) @(negedge clk);
    issue(8'h09, 8'h04, 1'b1, 8'h05, 1'b0);
    wait_done(W);
    @(negedge clk);

    // Back-to-back: start in the DONE cycle.
    issue(8'h05, 8'h03, 1'b1, 8'h02, 1'b0);
    wait_done(W);
    issue(8'h01, 8'h02, 1'b1, 8'hFF, 1'b1);
    chk("b2b_busy_immediately", {31'd0, busy}, 32'd1);
    chk("b2b_prev_diff_held", {24'd0, diff}, 32'h02);
    wait_done(W);
    repeat (3) @(negedge clk);
    chk("final_queue_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
